dbg_mem_sequencer: RTL

- UART-side controller that sequences debug accesses to the instruction and data memories.
- Assembles command frames from the UART receiver and stalls the CPU by dropping `enable`.
- Issues a single-cycle memory request with the `write_mem_req` / `target_mem_type` / `target_addr` / `rw_flag` / `uart_rx_data_in` signals, and collects the 42-bit read response.
- Serializes responses back to the UART transmitter byte by byte.
- Sits between the UART RX/TX cores and both memories.

---
 rtl/dbg_mem_sequencer.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/dbg_mem_sequencer.sv
// Debug memory sequencer: assembles UART command frames, stalls the CPU, issues a
// single memory request and streams the response back to the UART transmitter.
module dbg_mem_sequencer #(
  parameter int DRAIN_CYCLES = 2,
  parameter int RESP_TIMEOUT = 15,
  parameter int BYTE_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        cpu_enable,
  output logic        write_mem_req,
  output logic        target_mem_type,
  output logic [8:0]  target_addr,
  output logic        rw_flag,
  output logic [31:0] uart_rx_data_in,
  input  logic [41:0] mem_tx_data_in,
  input  logic        mem_tx_data_ready,
  output logic        err_timeout
);

  localparam int CMAX_RB = (RESP_TIMEOUT > BYTE_TIMEOUT) ? RESP_TIMEOUT : BYTE_TIMEOUT;
  localparam int CMAX    = (DRAIN_CYCLES > CMAX_RB) ? DRAIN_CYCLES : CMAX_RB;
  localparam int CW      = $clog2(CMAX + 1);
  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);
  localparam logic [CW-1:0] RESP_LAST  = CW'(RESP_TIMEOUT - 1);
  localparam logic [CW-1:0] BYTE_LAST  = CW'(BYTE_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_DATA, S_HALT, S_REQ, S_WAIT, S_ACK, S_TX, S_RESUME
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic          hdr_rw_q, hdr_rw_d, hdr_type_q, hdr_type_d, hdr_a8_q, hdr_a8_d;
  logic [7:0]    addr_lo_q, addr_lo_d;
  logic [23:0]   wdata_q, wdata_d;
  logic [47:0]   shift_q, shift_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_start_q, tx_start_d;
  logic          cpu_enable_q, cpu_enable_d;
  logic          write_mem_req_q, write_mem_req_d;
  logic          target_mem_type_q, target_mem_type_d;
  logic [8:0]    target_addr_q, target_addr_d;
  logic          rw_flag_q, rw_flag_d;
  logic [31:0]   uart_rx_data_in_q, uart_rx_data_in_d;
  logic          err_timeout_q, err_timeout_d;

  // Frame parsing, access sequencing and response serialisation.
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q + CNT_ONE;
    bcnt_d            = bcnt_q;
    hdr_rw_d          = hdr_rw_q;
    hdr_type_d        = hdr_type_q;
    hdr_a8_d          = hdr_a8_q;
    addr_lo_d         = addr_lo_q;
    wdata_d           = wdata_q;
    shift_d           = shift_q;
    tx_data_d         = tx_data_q;
    tx_start_d        = 1'b0;
    target_mem_type_d = target_mem_type_q;
    target_addr_d     = target_addr_q;
    rw_flag_d         = rw_flag_q;
    uart_rx_data_in_d = uart_rx_data_in_q;
    err_timeout_d     = err_timeout_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = CNT_ZERO;
        if (rx_valid) begin
          hdr_rw_d   = rx_data[7];
          hdr_type_d = rx_data[6];
          hdr_a8_d   = rx_data[0];
          state_d    = S_HDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HDR: begin
        if (rx_valid) begin
          cnt_d     = CNT_ZERO;
          addr_lo_d = rx_data;
          bcnt_d    = 3'd0;
          if (hdr_rw_q) begin
            state_d = S_DATA;
          end else begin
            state_d           = S_HALT;
            target_mem_type_d = hdr_type_q;
            target_addr_d     = {hdr_a8_q, rx_data};
            rw_flag_d         = 1'b0;
          end
        end else if (cnt_q == BYTE_LAST) begin
          cnt_d   = CNT_ZERO;
          state_d = S_IDLE;
        end else begin
          state_d = S_HDR;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          cnt_d   = CNT_ZERO;
          wdata_d = {wdata_q[15:0], rx_data};
          if (bcnt_q == 3'd3) begin
            state_d           = S_HALT;
            target_mem_type_d = hdr_type_q;
            target_addr_d     = {hdr_a8_q, addr_lo_q};
            rw_flag_d         = 1'b1;
            uart_rx_data_in_d = {wdata_q, rx_data};
          end else begin
            bcnt_d = bcnt_q + 3'd1;
          end
        end else if (cnt_q == BYTE_LAST) begin
          cnt_d   = CNT_ZERO;
          state_d = S_IDLE;
        end else begin
          state_d = S_DATA;
        end
      end
      S_HALT: begin
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = CNT_ZERO;
          state_d = S_REQ;
        end else begin
          state_d = S_HALT;
        end
      end
      S_REQ: begin
        cnt_d   = CNT_ZERO;
        state_d = rw_flag_q ? S_ACK : S_WAIT;
      end
      S_WAIT: begin
        // A ready pulse on the final timeout cycle still wins over the error.
        if (mem_tx_data_ready) begin
          shift_d = {6'b000000, mem_tx_data_in};
          bcnt_d  = 3'd6;
          state_d = S_TX;
        end else if (cnt_q == RESP_LAST) begin
          err_timeout_d = 1'b1;
          shift_d       = {8'hEE, 40'h00_0000_0000};
          bcnt_d        = 3'd1;
          state_d       = S_TX;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_ACK: begin
        shift_d = {8'hA5, 40'h00_0000_0000};
        bcnt_d  = 3'd1;
        state_d = S_TX;
      end
      S_TX: begin
        if (!tx_busy && !tx_start_q) begin
          tx_start_d = 1'b1;
          tx_data_d  = shift_q[47:40];
          shift_d    = {shift_q[39:0], 8'h00};
          bcnt_d     = bcnt_q - 3'd1;
          state_d    = (bcnt_q == 3'd1) ? S_RESUME : S_TX;
        end else begin
          state_d = S_TX;
        end
      end
      S_RESUME: begin
        cnt_d   = CNT_ZERO;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = CNT_ZERO;
        state_d = S_IDLE;
      end
    endcase
    cpu_enable_d    = (state_d == S_IDLE) || (state_d == S_HDR) || (state_d == S_DATA);
    write_mem_req_d = (state_d == S_REQ);
  end

  // State and registered outputs; reset aborts any access and releases the CPU.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= S_IDLE;
      cnt_q             <= CNT_ZERO;
      bcnt_q            <= 3'd0;
      hdr_rw_q          <= 1'b0;
      hdr_type_q        <= 1'b0;
      hdr_a8_q          <= 1'b0;
      addr_lo_q         <= 8'h00;
      wdata_q           <= 24'h00_0000;
      shift_q           <= 48'h0000_0000_0000;
      tx_data_q         <= 8'h00;
      tx_start_q        <= 1'b0;
      cpu_enable_q      <= 1'b1;
      write_mem_req_q   <= 1'b0;
      target_mem_type_q <= 1'b0;
      target_addr_q     <= 9'h000;
      rw_flag_q         <= 1'b0;
      uart_rx_data_in_q <= 32'h0000_0000;
      err_timeout_q     <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      bcnt_q            <= bcnt_d;
      hdr_rw_q          <= hdr_rw_d;
      hdr_type_q        <= hdr_type_d;
      hdr_a8_q          <= hdr_a8_d;
      addr_lo_q         <= addr_lo_d;
      wdata_q           <= wdata_d;
      shift_q           <= shift_d;
      tx_data_q         <= tx_data_d;
      tx_start_q        <= tx_start_d;
      cpu_enable_q      <= cpu_enable_d;
      write_mem_req_q   <= write_mem_req_d;
      target_mem_type_q <= target_mem_type_d;
      target_addr_q     <= target_addr_d;
      rw_flag_q         <= rw_flag_d;
      uart_rx_data_in_q <= uart_rx_data_in_d;
      err_timeout_q     <= err_timeout_d;
    end
  end

  assign tx_data         = tx_data_q;
  assign tx_start        = tx_start_q;
  assign cpu_enable      = cpu_enable_q;
  assign write_mem_req   = write_mem_req_q;
  assign target_mem_type = target_mem_type_q;
  assign target_addr     = target_addr_q;
  assign rw_flag         = rw_flag_q;
  assign uart_rx_data_in = uart_rx_data_in_q;
  assign err_timeout     = err_timeout_q;

endmodule
